// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the button/LED sequencer: mode and shift-direction types
// plus the mode-advance rule used by the sequencer FSM.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        unique case (m)
            MODE_OFF:    n = MODE_MANUAL;
            MODE_MANUAL: n = MODE_SHIFT;
            MODE_SHIFT:  n = MODE_BLINK;
            MODE_BLINK:  n = MODE_OFF;
        endcase
        return n;
    endfunction

    function automatic dir_e flip_dir(input dir_e d);
        return (d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One active-low push button: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press (debounced 1->0).
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_raw,
    output logic level,
    output logic press
);

    localparam int unsigned       CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            cnt    <= '0;
            level  <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Level accepted after DEBOUNCE_CYCLES consecutive mismatching samples
                level <= sync_2;
                cnt   <= '0;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Button-driven LED sequencer: debounced buttons step a 4-mode FSM
// (off / manual latch / running light / blink) that drives the LED bank.
module led_seq_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned STEP_CYCLES     = 6750000,
    parameter int unsigned LED_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic             running
);

    localparam int unsigned       STEP_W   = $clog2(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_CYCLES - 1);
    localparam logic [LED_W-1:0]  LED_BIT0 = {{(LED_W-1){1'b0}}, 1'b1};

    mode_e             mode_q;
    dir_e              dir_q;
    logic [2:0]        press;
    logic [2:0]        btn_level_unused;
    logic [STEP_W-1:0] step_cnt;
    logic              step_mode;
    logic              tick;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n_raw (btn[0]),
        .level     (btn_level_unused[0]),
        .press     (press[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_action (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n_raw (btn[1]),
        .level     (btn_level_unused[1]),
        .press     (press[1])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_run (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n_raw (btn[2]),
        .level     (btn_level_unused[2]),
        .press     (press[2])
    );

    function automatic logic [LED_W-1:0] entry_led(input mode_e m);
        logic [LED_W-1:0] v;
        unique case (m)
            MODE_OFF:    v = '0;
            MODE_MANUAL: v = '0;
            MODE_SHIFT:  v = LED_BIT0;
            MODE_BLINK:  v = '1;
        endcase
        return v;
    endfunction

    assign step_mode = (mode_q == MODE_SHIFT) || (mode_q == MODE_BLINK);
    assign tick      = running && step_mode && (step_cnt == STEP_MAX);
    assign mode      = mode_q;

    // Prescaler: frozen while paused, cleared outside SHIFT/BLINK and on every mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (press[0] || !step_mode) begin
            step_cnt <= '0;
        end else if (running) begin
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OFF;
            dir_q   <= DIR_LEFT;
            led     <= '0;
            running <= 1'b1;
        end else begin
            if (press[2]) begin
                running <= ~running;
            end
            // A mode change overrides any action press or tick in the same cycle
            if (press[0]) begin
                mode_q <= next_mode(mode_q);
                dir_q  <= DIR_LEFT;
                led    <= entry_led(next_mode(mode_q));
            end else begin
                unique case (mode_q)
                    MODE_OFF: begin
                        led <= '0;
                    end
                    MODE_MANUAL: begin
                        led <= {{(LED_W-1){1'b0}}, led[0] ^ press[1]};
                    end
                    MODE_SHIFT: begin
                        if (tick) begin
                            led <= (dir_q == DIR_LEFT) ? {led[LED_W-2:0], led[LED_W-1]}
                                                       : {led[0], led[LED_W-1:1]};
                        end
                        if (press[1]) begin
                            dir_q <= flip_dir(dir_q);
                        end
                    end
                    MODE_BLINK: begin
                        if (tick ^ press[1]) begin
                            led <= ~led;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed and random button activity
// compared every cycle against a behavioural model of the sequencer.
module tb_led_seq_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned S = 8;
    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   btn;
    logic [W-1:0] led;
    logic [1:0]   mode;
    logic         running;

    led_seq_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .STEP_CYCLES     (S),
        .LED_W           (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .led     (led),
        .mode    (mode),
        .running (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ev_cyc[3];

    // Behavioural model state
    int m_mode;
    bit m_run;
    int m_act;     // running clocks spent in the current SHIFT/BLINK visit
    int m_pos;     // lit position in SHIFT
    bit m_right;
    bit m_b0;
    bit m_lit;

    function automatic logic [W-1:0] model_led();
        logic [W-1:0] one;
        one = W'(1);
        case (m_mode)
            0:       return '0;
            1:       return m_b0 ? one : '0;
            2:       return one << m_pos;
            default: return m_lit ? '1 : '0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_run   = 1'b1;
        m_act   = 0;
        m_pos   = 0;
        m_right = 1'b0;
        m_b0    = 1'b0;
        m_lit   = 1'b0;
        for (int b = 0; b < 3; b++) ev_cyc[b] = -1;
    endtask

    task automatic model_step(input bit p0, input bit p1, input bit p2);
        bit tick;
        tick = 1'b0;
        if (m_mode >= 2 && m_run) begin
            m_act++;
            tick = (m_act % S == 0);
        end
        if (p0) begin
            m_mode  = (m_mode + 1) % 4;
            m_act   = 0;
            m_pos   = 0;
            m_right = 1'b0;
            m_b0    = 1'b0;
            m_lit   = (m_mode == 3);
        end else if (m_mode == 1) begin
            if (p1) m_b0 = !m_b0;
        end else if (m_mode == 2) begin
            if (tick) m_pos = m_right ? (m_pos + W - 1) % W : (m_pos + 1) % W;
            if (p1) m_right = !m_right;
        end else if (m_mode == 3) begin
            if (tick) m_lit = !m_lit;
            if (p1)   m_lit = !m_lit;
        end
        if (p2) m_run = !m_run;
    endtask

    task automatic check_outputs(input string tag);
        logic [W-1:0] el;
        logic [1:0]   em;
        el = model_led();
        em = 2'(m_mode);
        checks++;
        assert (led === el) else begin
            errors++;
            $error("FAIL %s led cyc=%0d observed %b expected %b", tag, cyc, led, el);
        end
        checks++;
        assert (mode === em) else begin
            errors++;
            $error("FAIL %s mode cyc=%0d observed %b expected %b", tag, cyc, mode, em);
        end
        checks++;
        assert (running === m_run) else begin
            errors++;
            $error("FAIL %s running cyc=%0d observed %b expected %b", tag, cyc, running, m_run);
        end
    endtask

    task automatic cycle(input string tag);
        bit p[3];
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int b = 0; b < 3; b++) begin
                p[b] = (ev_cyc[b] == cyc);
                if (p[b]) ev_cyc[b] = -1;
            end
            model_step(p[0], p[1], p[2]);
        end
        #1;
        check_outputs(tag);
    endtask

    // Hold the buttons in mask low for h clocks, then release and let them settle.
    // An accepted press reaches the FSM D+3 edges after the raw edge is driven.
    task automatic hold(input logic [2:0] mask, input int h, input string tag);
        btn = ~mask;
        if (h >= int'(D)) begin
            for (int b = 0; b < 3; b++) if (mask[b]) ev_cyc[b] = cyc + int'(D) + 3;
        end
        repeat (h) cycle(tag);
        btn = 3'b111;
        repeat (D + 4) cycle(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) cycle(tag);
    endtask

    initial begin
        logic [2:0] rmask;
        int         rh;

        btn   = 3'b111;
        rst_n = 1'b0;
        model_reset();
        idle(3, "reset");
        rst_n = 1'b1;
        idle(50, "idle_after_reset");

        hold(3'b001, 3, "glitch_mode");
        idle(10, "glitch_settle");
        hold(3'b001, 10, "to_manual");

        hold(3'b010, 6, "manual_toggle_on");
        hold(3'b010, 6, "manual_toggle_off");

        hold(3'b001, 6, "to_shift");
        idle(45, "shift_left");
        hold(3'b010, 6, "shift_dir_flip");
        idle(20, "shift_right");

        hold(3'b001, 6, "to_blink");
        idle(20, "blink");
        hold(3'b100, 6, "pause");
        idle(100, "paused");
        hold(3'b100, 6, "resume");
        idle(30, "resumed");

        hold(3'b001, 6, "to_off");
        hold(3'b001, 6, "off_to_manual");
        hold(3'b011, 6, "mode_and_action");
        idle(10, "shift_after_combo");

        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        btn = 3'b110;
        idle(3, "reset_held_btn");
        rst_n = 1'b1;
        ev_cyc[0] = cyc + int'(D) + 3;
        idle(10, "btn_held_through_reset");
        btn = 3'b111;
        idle(D + 4, "release_after_reset");

        for (int i = 0; i < 60; i++) begin
            rmask = 3'($urandom_range(1, 7));
            rh    = int'($urandom_range(1, 10));
            hold(rmask, rh, "random");
            idle(int'($urandom_range(0, 25)), "random_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
